// File: rtl/chunked_adder_pkg.sv
// chunked_adder_pkg
//   Shared types and defaults for the chunked (multi-cycle) adder.
//   state_t       : controller states IDLE / RUN / DONE
//   DEFAULT_WIDTH : default operand/result width in bits
//   DEFAULT_CHUNK : default bits added per clock cycle
package chunked_adder_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;
    localparam int unsigned DEFAULT_CHUNK = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/chunked_adder_chunk.sv
// adder_chunk
//   Combinational CHUNK-bit adder slice used once per beat by chunked_adder.
//   Ports:
//     a, b  : CHUNK-bit addends
//     cin   : carry into bit 0
//     s     : CHUNK-bit sum
//     cout  : carry out of the top bit
//     cmsb  : carry into the top bit (for two's-complement overflow)
module adder_chunk
    import chunked_adder_pkg::*;
#(
    parameter int unsigned CHUNK = DEFAULT_CHUNK
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout,
    output logic             cmsb
);

    assign {cout, s} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

    // Sum bit = a ^ b ^ carry_in at that position, so the carry into the
    // top bit falls out without a separate ripple; also valid for CHUNK = 1.
    assign cmsb = s[CHUNK-1] ^ a[CHUNK-1] ^ b[CHUNK-1];

endmodule

// File: rtl/chunked_adder.sv
// chunked_adder
//   Multi-cycle adder/subtractor: adds CHUNK bits per clock over
//   N = WIDTH/CHUNK beats, then presents the result for one DONE cycle.
//   Ports:
//     clk       : clock, rising edge
//     rst       : synchronous active-high reset
//     start     : begin an operation (accepted when busy = 0)
//     sub       : 0 = a + b + carry_in, 1 = a - b
//     a, b      : WIDTH-bit operands
//     carry_in  : carry into LSB in add mode
//     busy      : high while in RUN
//     done      : one-cycle result-valid pulse
//     sum       : WIDTH-bit result (held until the next completed operation)
//     carry_out : carry out of MSB (in subtract mode 1 = no borrow)
//     overflow  : two's-complement overflow
module chunked_adder
    import chunked_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CHUNK = DEFAULT_CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int unsigned N  = WIDTH / CHUNK;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    if ((WIDTH % CHUNK) != 0) begin : g_width_check
        $error("chunked_adder: WIDTH (%0d) must be a multiple of CHUNK (%0d)", WIDTH, CHUNK);
    end

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    beat;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;      // effective operand: b or ~b
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_next;
    logic             carry;     // registered inter-chunk carry
    logic [31:0]      base;
    logic [CHUNK-1:0] chunk_s;
    logic             chunk_cout;
    logic             chunk_cmsb;
    logic             accept;
    logic             last;

    assign accept = start && (state != RUN);
    assign last   = (beat == CW'(N - 1));
    assign base   = 32'(beat) * CHUNK;

    adder_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a    (op_a[base +: CHUNK]),
        .b    (op_b[base +: CHUNK]),
        .cin  (carry),
        .s    (chunk_s),
        .cout (chunk_cout),
        .cmsb (chunk_cmsb)
    );

    // Result with the current beat's chunk merged in; on the last beat this
    // is the complete result and goes straight to sum.
    always_comb begin
        res_next                 = res;
        res_next[base +: CHUNK]  = chunk_s;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last)  state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            beat      <= '0;
            op_a      <= '0;
            op_b      <= '0;
            res       <= '0;
            carry     <= 1'b0;
            sum       <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else if (accept) begin
            beat  <= '0;
            op_a  <= a;
            op_b  <= sub ? ~b : b;
            carry <= sub ? 1'b1 : carry_in;
        end else if (state == RUN) begin
            res   <= res_next;
            carry <= chunk_cout;
            // Wrap to 0 rather than count past N-1 so the part-select stays in range.
            beat  <= last ? '0 : beat + 1'b1;
            if (last) begin
                sum       <= res_next;
                carry_out <= chunk_cout;
                overflow  <= chunk_cmsb ^ chunk_cout;
            end
        end
    end

endmodule
